// File: rtl/lcg_stim_gen.sv
// lcg_stim_gen: parametrised stimulus source for fuzz harnesses.
// Each beat is OUT_W bits wide and is built one 32-bit word per cycle into a
// shadow buffer. The word source is a 32-bit LCG, the running beat count, or
// a seed latched at start. Beats are reproducible for a given seed.
//
// Handshake: stim_valid rises when a beat is complete and then stays high,
// with stim_flat held stable, until the cycle in which stim_ready is high.
// A beat is transferred exactly on a rising edge where stim_valid && stim_ready.
// stim_ready has no effect while stim_valid is low. The next beat is never
// pre-built while one is presented, so the LCG advances only during FILL.
module lcg_stim_gen #(
    parameter int          OUT_W        = 264,
    parameter int          CNT_W        = 16,
    parameter logic [31:0] SEED_DEFAULT = 32'd397356838
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             seed_load,
    input  logic [31:0]      seed,
    input  logic [1:0]       mode,
    input  logic [CNT_W-1:0] cycles,
    input  logic             stim_ready,
    output logic             stim_valid,
    output logic [OUT_W-1:0] stim_flat,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] beat_cnt,
    output logic [1:0]       dbg_state
);

    // Number of 32-bit words per beat; the top word may be partly unused.
    localparam int NW    = (OUT_W + 31) / 32;
    localparam int BUF_W = NW * 32;
    localparam int IDX_W = (NW > 1) ? $clog2(NW) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NW - 1);

    localparam logic [31:0] LCG_MUL = 32'h41C64E6D;
    localparam logic [31:0] LCG_INC = 32'h0000_3039;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_FILL    = 2'd1,
        S_PRESENT = 2'd2
    } state_t;

    state_t             state_q,    state_d;
    logic [31:0]        lcg_q,      lcg_d;
    logic [1:0]         mode_q,     mode_d;
    logic [CNT_W-1:0]   cycles_q,   cycles_d;
    logic [31:0]        seed_lat_q, seed_lat_d;
    logic [IDX_W-1:0]   idx_q,      idx_d;
    logic [BUF_W-1:0]   shadow_q,   shadow_d;
    logic [OUT_W-1:0]   flat_q,     flat_d;
    logic               valid_q,    valid_d;
    logic               done_q,     done_d;
    logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;

    logic [31:0]        lcg_next;
    logic [31:0]        fill_word;
    logic               lcg_mode;
    logic               last_beat;

    // Word source for the current FILL cycle, selected by the latched mode.
    always_comb begin
        lcg_next  = (lcg_q * LCG_MUL) + LCG_INC;
        lcg_mode  = (mode_q == 2'd0) || (mode_q == 2'd3);
        last_beat = ((beat_cnt_q + CNT_W'(1)) == cycles_q);
        case (mode_q)
            2'd1:    fill_word = 32'(beat_cnt_q) + 32'(idx_q);
            2'd2:    fill_word = seed_lat_q;
            default: fill_word = lcg_next;
        endcase
    end

    // Control FSM next-state logic; abort overrides every state.
    always_comb begin
        state_d    = state_q;
        lcg_d      = lcg_q;
        mode_d     = mode_q;
        cycles_d   = cycles_q;
        seed_lat_d = seed_lat_q;
        idx_d      = idx_q;
        shadow_d   = shadow_q;
        flat_d     = flat_q;
        valid_d    = valid_q;
        done_d     = 1'b0;
        beat_cnt_d = beat_cnt_q;

        if (abort) begin
            // Keep lcg, stim_flat and beat_cnt so a later run resumes the chain.
            state_d = S_IDLE;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // Seed load takes effect at the same edge as start, so the
                    // first FILL cycle already steps from the new seed.
                    if (seed_load) begin
                        lcg_d = seed;
                    end
                    if (start) begin
                        mode_d     = mode;
                        cycles_d   = cycles;
                        seed_lat_d = seed;
                        beat_cnt_d = '0;
                        if (cycles == '0) begin
                            done_d = 1'b1;
                        end else begin
                            idx_d   = '0;
                            state_d = S_FILL;
                        end
                    end
                end

                S_FILL: begin
                    if (lcg_mode) begin
                        lcg_d = lcg_next;
                    end
                    for (int k = 0; k < NW; k++) begin
                        if (idx_q == IDX_W'(k)) begin
                            shadow_d[k*32 +: 32] = fill_word;
                        end
                    end
                    if (idx_q == IDX_LAST) begin
                        // Publish the whole beat, including the word written now.
                        flat_d  = shadow_d[OUT_W-1:0];
                        valid_d = 1'b1;
                        state_d = S_PRESENT;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end

                S_PRESENT: begin
                    if (stim_ready) begin
                        beat_cnt_d = beat_cnt_q + CNT_W'(1);
                        valid_d    = 1'b0;
                        if (last_beat) begin
                            done_d  = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            idx_d   = '0;
                            state_d = S_FILL;
                        end
                    end
                end

                default: begin
                    state_d = S_IDLE;
                    valid_d = 1'b0;
                end
            endcase
        end
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            lcg_q      <= SEED_DEFAULT;
            mode_q     <= 2'd0;
            cycles_q   <= '0;
            seed_lat_q <= '0;
            idx_q      <= '0;
            shadow_q   <= '0;
            flat_q     <= '0;
            valid_q    <= 1'b0;
            done_q     <= 1'b0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            lcg_q      <= lcg_d;
            mode_q     <= mode_d;
            cycles_q   <= cycles_d;
            seed_lat_q <= seed_lat_d;
            idx_q      <= idx_d;
            shadow_q   <= shadow_d;
            flat_q     <= flat_d;
            valid_q    <= valid_d;
            done_q     <= done_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    // All outputs come straight from registers.
    always_comb begin
        stim_valid = valid_q;
        stim_flat  = flat_q;
        busy       = (state_q == S_FILL) || (state_q == S_PRESENT);
        done       = done_q;
        beat_cnt   = beat_cnt_q;
        dbg_state  = state_q;
    end

endmodule

// File: tb/tb_lcg_stim_gen.sv
// tb_lcg_stim_gen: directed bench for lcg_stim_gen.
// Instance 0 uses OUT_W=64 (two words per beat), instance 1 the default
// OUT_W=264 (nine words, top word truncated to 8 bits). Expected beats are
// produced by a software LCG model and queued before each run starts.
module tb_lcg_stim_gen;

    localparam int          CW       = 16;
    localparam logic [31:0] SEED_DEF = 32'd397356838;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // ---------------- DUT wiring ----------------
    logic [1:0]    start_s, seed_load_s, abort_s, ready_s;
    logic [31:0]   seed_s   [2];
    logic [1:0]    mode_s   [2];
    logic [CW-1:0] cycles_s [2];

    logic          a_valid, a_busy, a_done, b_valid, b_busy, b_done;
    logic [CW-1:0] a_cnt, b_cnt;
    logic [1:0]    a_dbg, b_dbg;
    logic [63:0]   a_flat;
    logic [263:0]  b_flat;

    lcg_stim_gen #(.OUT_W(64), .CNT_W(CW), .SEED_DEFAULT(SEED_DEF)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_s[0]), .abort(abort_s[0]),
        .seed_load(seed_load_s[0]), .seed(seed_s[0]), .mode(mode_s[0]),
        .cycles(cycles_s[0]), .stim_ready(ready_s[0]), .stim_valid(a_valid),
        .stim_flat(a_flat), .busy(a_busy), .done(a_done), .beat_cnt(a_cnt),
        .dbg_state(a_dbg)
    );

    lcg_stim_gen dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_s[1]), .abort(abort_s[1]),
        .seed_load(seed_load_s[1]), .seed(seed_s[1]), .mode(mode_s[1]),
        .cycles(cycles_s[1]), .stim_ready(ready_s[1]), .stim_valid(b_valid),
        .stim_flat(b_flat), .busy(b_busy), .done(b_done), .beat_cnt(b_cnt),
        .dbg_state(b_dbg)
    );

    // View of the instance currently under test.
    int            sel = 0;
    logic          o_valid, o_busy, o_done;
    logic [CW-1:0] o_cnt;
    logic [263:0]  o_flat;

    always_comb begin
        if (sel == 1) begin
            o_valid = b_valid; o_busy = b_busy; o_done = b_done;
            o_cnt   = b_cnt;   o_flat = b_flat;
        end else begin
            o_valid = a_valid; o_busy = a_busy; o_done = a_done;
            o_cnt   = a_cnt;   o_flat = {200'd0, a_flat};
        end
    end

    // ---------------- scoreboard ----------------
    logic [263:0] exp_q[$];
    logic [263:0] last_exp;
    logic [31:0]  m_lcg [2];
    int           n_assert = 0;
    int           n_fail   = 0;

    function automatic logic [31:0] lcg_step(input logic [31:0] s);
        return (s * 32'h41C64E6D) + 32'h0000_3039;
    endfunction

    task automatic check(input string tag, input logic [263:0] obs, input logic [263:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Queue nbeats LCG-filled beats for instance s, advancing the model.
    task automatic push_lcg(input int s, input int nbeats);
        int           ow;
        int           nw;
        logic [287:0] full;
        logic [263:0] mask;
        ow   = (s == 1) ? 264 : 64;
        nw   = (ow + 31) / 32;
        mask = '1;
        mask = mask >> (264 - ow);
        for (int b = 0; b < nbeats; b++) begin
            full = '0;
            for (int k = 0; k < nw; k++) begin
                m_lcg[s] = lcg_step(m_lcg[s]);
                full[k*32 +: 32] = m_lcg[s];
            end
            exp_q.push_back(full[263:0] & mask);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input int s, input logic ld, input logic [31:0] sd,
                             input logic [1:0] md, input logic [CW-1:0] cyc);
        sel            = s;
        seed_load_s[s] = ld;
        seed_s[s]      = sd;
        mode_s[s]      = md;
        cycles_s[s]    = cyc;
        start_s[s]     = 1'b1;
        tick();
        start_s[s]     = 1'b0;
        seed_load_s[s] = 1'b0;
    endtask

    // Wait for a beat (bounded), compare it with the queue head, then let it be accepted.
    task automatic collect_beat(input string tag, input bit rnd, output int waited);
        logic [263:0] e;
        bit           got;
        waited = 0;
        got    = 1'b0;
        for (int i = 0; i < 200; i++) begin
            ready_s[sel] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (o_valid && ready_s[sel]) begin
                got = 1'b1;
                break;
            end
            tick();
            waited++;
        end
        check({tag, "_seen"}, 264'(got), 264'd1);
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else                  e = '1;
        check(tag, o_flat, e);
        last_exp = e;
        tick();
    endtask

    // ---------------- directed sequence ----------------
    int           w;
    int           n;
    int           unstable;
    logic [263:0] held;

    initial begin
        start_s = '0; seed_load_s = '0; abort_s = '0; ready_s = '0;
        for (int i = 0; i < 2; i++) begin
            seed_s[i] = '0; mode_s[i] = '0; cycles_s[i] = '0;
        end
        m_lcg[0] = SEED_DEF;
        m_lcg[1] = SEED_DEF;

        // Reset values
        repeat (3) tick();
        check("rst_a_valid", 264'(a_valid), 264'd0);
        check("rst_a_busy",  264'(a_busy),  264'd0);
        check("rst_a_done",  264'(a_done),  264'd0);
        check("rst_a_cnt",   264'(a_cnt),   264'd0);
        check("rst_a_flat",  264'(a_flat),  264'd0);
        check("rst_b_flat",  b_flat,        264'd0);
        check("rst_b_valid", 264'(b_valid), 264'd0);
        rst_n = 1'b1;
        tick();

        // Seed 0, one beat, OUT_W=64
        sel = 0;
        seed_s[0] = 32'd0; seed_load_s[0] = 1'b1;
        tick();
        seed_load_s[0] = 1'b0;
        exp_q.push_back(264'h0000_0000_0000_0000_D3DC167E_00003039);
        m_lcg[0] = 32'hD3DC167E;
        ready_s[0] = 1'b1;
        start_run(0, 1'b0, 32'd0, 2'd0, 16'd1);
        collect_beat("t1_beat", 1'b0, w);
        check("t1_latency", 264'(w), 264'd2);
        check("t1_done",    264'(o_done),  264'd1);
        check("t1_cnt",     264'(o_cnt),   264'd1);
        check("t1_valid",   264'(o_valid), 264'd0);
        tick();
        check("t1_done_pulse", 264'(o_done), 264'd0);

        // Default width, default seed, three chained beats
        push_lcg(1, 3);
        ready_s[1] = 1'b1;
        start_run(1, 1'b0, 32'd0, 2'd0, 16'd3);
        collect_beat("t2_beat0", 1'b0, w);
        check("t2_lat0", 264'(w), 264'd9);
        check("t2_no_done", 264'(o_done), 264'd0);
        collect_beat("t2_beat1", 1'b0, w);
        check("t2_lat1", 264'(w), 264'd9);
        collect_beat("t2_beat2", 1'b0, w);
        check("t2_lat2", 264'(w), 264'd9);
        check("t2_done", 264'(o_done), 264'd1);
        check("t2_cnt",  264'(o_cnt),  264'd3);
        check("t2_busy", 264'(o_busy), 264'd0);

        // Backpressure: hold ready low for 20 cycles in PRESENT
        push_lcg(1, 2);
        ready_s[1] = 1'b0;
        start_run(1, 1'b0, 32'd0, 2'd0, 16'd2);
        n = 0;
        while (!o_valid && n < 50) begin
            tick();
            n++;
        end
        check("t3_valid_up", 264'(o_valid), 264'd1);
        held = o_flat;
        unstable = 0;
        repeat (20) begin
            tick();
            if (!o_valid || o_flat !== held) unstable++;
        end
        check("t3_stable",   264'(unstable), 264'd0);
        check("t3_cnt_hold", 264'(o_cnt),    264'd0);
        collect_beat("t3_beat0", 1'b0, w);
        check("t3_cnt1", 264'(o_cnt), 264'd1);
        collect_beat("t3_beat1", 1'b1, w);
        check("t3_cnt2", 264'(o_cnt),  264'd2);
        check("t3_done", 264'(o_done), 264'd1);

        // Count mode; mode/cycles changes mid-run must be ignored
        exp_q.push_back(264'h0000_0001_0000_0000);
        exp_q.push_back(264'h0000_0002_0000_0001);
        exp_q.push_back(264'h0000_0003_0000_0002);
        ready_s[0] = 1'b1;
        start_run(0, 1'b0, 32'd0, 2'd1, 16'd3);
        mode_s[0] = 2'd0;
        cycles_s[0] = 16'd1;
        collect_beat("t4_cnt_beat0", 1'b0, w);
        collect_beat("t4_cnt_beat1", 1'b1, w);
        collect_beat("t4_cnt_beat2", 1'b0, w);
        check("t4_done", 264'(o_done), 264'd1);
        check("t4_cnt",  264'(o_cnt),  264'd3);

        // Count mode must not have stepped the LCG
        push_lcg(0, 1);
        start_run(0, 1'b0, 32'd0, 2'd0, 16'd1);
        collect_beat("t4_lcg_cont", 1'b0, w);
        check("t4_lat", 264'(w), 264'd2);

        // Replicate-seed mode (seed loaded too, which resets the LCG chain)
        exp_q.push_back(264'hA5A5A5A5_A5A5A5A5);
        exp_q.push_back(264'hA5A5A5A5_A5A5A5A5);
        m_lcg[0] = 32'hA5A5A5A5;
        start_run(0, 1'b1, 32'hA5A5A5A5, 2'd2, 16'd2);
        collect_beat("t5_rep_beat0", 1'b0, w);
        collect_beat("t5_rep_beat1", 1'b0, w);
        check("t5_done", 264'(o_done), 264'd1);

        // Abort during FILL of beat 2, after one word
        push_lcg(0, 1);
        start_run(0, 1'b0, 32'd0, 2'd0, 16'd3);
        collect_beat("t6_beat0", 1'b0, w);
        tick();
        m_lcg[0] = lcg_step(m_lcg[0]);
        abort_s[0] = 1'b1;
        tick();
        abort_s[0] = 1'b0;
        check("t6_valid",     264'(o_valid), 264'd0);
        check("t6_busy",      264'(o_busy),  264'd0);
        check("t6_done",      264'(o_done),  264'd0);
        check("t6_cnt_keep",  264'(o_cnt),   264'd1);
        check("t6_flat_hold", o_flat,        last_exp);
        check("t6_state",     264'(a_dbg),   264'd0);
        tick();
        check("t6_no_done", 264'(o_done), 264'd0);
        start_run(0, 1'b0, 32'd0, 2'd0, 16'd0);
        check("t6_zero_done", 264'(o_done), 264'd1);
        check("t6_zero_cnt",  264'(o_cnt),  264'd0);
        check("t6_zero_busy", 264'(o_busy), 264'd0);
        tick();
        check("t6_zero_pulse", 264'(o_done), 264'd0);
        push_lcg(0, 1);
        start_run(0, 1'b0, 32'd0, 2'd0, 16'd1);
        collect_beat("t6_resume", 1'b0, w);
        check("t6_resume_lat", 264'(w), 264'd2);

        // Asynchronous reset while presenting
        push_lcg(1, 1);
        ready_s[1] = 1'b0;
        start_run(1, 1'b0, 32'd0, 2'd0, 16'd1);
        n = 0;
        while (!o_valid && n < 50) begin
            tick();
            n++;
        end
        check("t7_valid_up", 264'(o_valid), 264'd1);
        exp_q.delete();
        #2;
        rst_n = 1'b0;
        #1;
        check("t7_rst_valid", 264'(b_valid), 264'd0);
        check("t7_rst_flat",  b_flat,        264'd0);
        check("t7_rst_busy",  264'(b_busy),  264'd0);
        check("t7_rst_cnt",   264'(b_cnt),   264'd0);
        check("t7_rst_done",  264'(b_done),  264'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        m_lcg[1] = SEED_DEF;

        // After reset the LCG restarts from the default seed (mode 3 = LCG)
        push_lcg(1, 1);
        ready_s[1] = 1'b1;
        start_run(1, 1'b0, 32'd0, 2'd3, 16'd1);
        collect_beat("t7_post_rst", 1'b0, w);
        check("t7_post_lat", 264'(w), 264'd9);

        // seed_load together with start: the fill uses the new seed
        m_lcg[1] = 32'h12345678;
        push_lcg(1, 2);
        start_run(1, 1'b1, 32'h12345678, 2'd0, 16'd2);
        collect_beat("t7_seed_beat0", 1'b0, w);
        collect_beat("t7_seed_beat1", 1'b1, w);
        check("t7_seed_done", 264'(o_done), 264'd1);
        check("t7_seed_cnt",  264'(o_cnt),  264'd2);

        check("queue_empty", 264'(exp_q.size()), 264'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
